// File: rtl/armleocpu_decode.sv
// rtl/armleocpu_decode.sv - decode stage: F2D pipeline register, D2E bus, D2F command path; opcode check under ARMLEOCPU_DECODE_OPCODE_CHECK_EN
`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 1
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif

module armleocpu_decode (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                f2d_valid,
    input  logic [`F2E_TYPE_WIDTH-1:0]          f2d_type,
    input  logic [31:0]                         f2d_instr,
    input  logic [31:0]                         f2d_pc,
    input  logic [3:0]                          f2d_resp,
    output logic                                d2f_ready,
    output logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd,
    output logic [31:0]                         d2f_branchtarget,
    input  logic                                e2d_ready,
    input  logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] e2d_cmd,
    input  logic [31:0]                         e2d_branchtarget,
    output logic                                d2e_valid,
    output logic [`F2E_TYPE_WIDTH-1:0]          d2e_type,
    output logic [31:0]                         d2e_instr,
    output logic [31:0]                         d2e_pc,
    output logic [3:0]                          d2e_resp,
    output logic                                d2e_illegal,
    output logic [4:0]                          rs1_addr,
    output logic [4:0]                          rs2_addr,
    output logic                                dbg_pipeline_busy
);
    localparam logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] CMD_NONE = '0;
    localparam logic [`F2E_TYPE_WIDTH-1:0] TYPE_INSTR = '0;
    localparam logic [`F2E_TYPE_WIDTH-1:0] TYPE_INTERRUPT_PENDING = `F2E_TYPE_WIDTH'(1);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
    state_t state, state_nxt;

    logic cmd_fwd, accept, serializing, is_instr, illegal;

    assign cmd_fwd  = e2d_ready && (e2d_cmd != CMD_NONE);
    assign accept   = f2d_valid && d2f_ready && !cmd_fwd;
    assign is_instr = (f2d_type == TYPE_INSTR) && (f2d_resp == 4'd0);
    assign serializing = (f2d_type == TYPE_INTERRUPT_PENDING) || (f2d_resp != 4'd0)
                      || (f2d_instr[6:0] == 7'b1110011) || (f2d_instr[6:0] == 7'b0001111);

`ifdef ARMLEOCPU_DECODE_OPCODE_CHECK_EN
    logic opcode_bad;
    always_comb begin
        opcode_bad = 1'b1;
        case (f2d_instr[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0001111, 7'b1110011:
                opcode_bad = 1'b0;
            // No M extension: only ADD/SUB-class funct7 encodings exist for OP
            7'b0110011:
                opcode_bad = !((f2d_instr[31:25] == 7'b0000000) || (f2d_instr[31:25] == 7'b0100000));
            default:
                opcode_bad = 1'b1;
        endcase
    end
    assign illegal = is_instr && ((f2d_instr[1:0] != 2'b11) || opcode_bad);
`else
    assign illegal = is_instr && (f2d_instr[1:0] != 2'b11);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cmd_fwd)
            state_nxt = RUN;
        else if (state == RUN) begin
            if (accept && serializing)
                state_nxt = HOLD;
        end else if (e2d_ready)
            state_nxt = RUN;
    end

    // The D2F path is purely combinational so fetch sees commands in the same cycle
    always_comb begin
        d2f_ready        = 1'b0;
        d2f_cmd          = CMD_NONE;
        d2f_branchtarget = e2d_branchtarget;
        if (!rst) begin
            if (cmd_fwd) begin
                d2f_ready = 1'b1;
                d2f_cmd   = e2d_cmd;
            end else if (state == RUN)
                d2f_ready = !d2e_valid || e2d_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d2e_valid   <= 1'b0;
            d2e_type    <= '0;
            d2e_instr   <= '0;
            d2e_pc      <= '0;
            d2e_resp    <= '0;
            d2e_illegal <= 1'b0;
        end else if (cmd_fwd) begin
            d2e_valid <= 1'b0;
        end else if (accept) begin
            d2e_valid   <= 1'b1;
            d2e_type    <= f2d_type;
            d2e_instr   <= f2d_instr;
            d2e_pc      <= f2d_pc;
            d2e_resp    <= f2d_resp;
            d2e_illegal <= illegal;
        end else if (e2d_ready) begin
            d2e_valid <= 1'b0;
        end
    end

    // While stalled, keep the regfile addressing the held entry so read data stays aligned
    assign rs1_addr = (d2f_ready && f2d_valid) ? f2d_instr[19:15] : d2e_instr[19:15];
    assign rs2_addr = (d2f_ready && f2d_valid) ? f2d_instr[24:20] : d2e_instr[24:20];

    assign dbg_pipeline_busy = d2e_valid || (state != RUN);
endmodule

// File: tb/tb_armleocpu_decode.sv
// tb/tb_armleocpu_decode.sv - self-checking bench for armleocpu_decode with a behavioural reference model
`ifndef F2E_TYPE_WIDTH
`define F2E_TYPE_WIDTH 1
`endif
`ifndef ARMLEOCPU_D2F_CMD_WIDTH
`define ARMLEOCPU_D2F_CMD_WIDTH 2
`endif

module tb_armleocpu_decode;
    logic        clk = 1'b0;
    logic        rst;
    logic        f2d_valid;
    logic [`F2E_TYPE_WIDTH-1:0] f2d_type;
    logic [31:0] f2d_instr, f2d_pc;
    logic [3:0]  f2d_resp;
    logic        d2f_ready;
    logic [`ARMLEOCPU_D2F_CMD_WIDTH-1:0] d2f_cmd, e2d_cmd;
    logic [31:0] d2f_branchtarget, e2d_branchtarget;
    logic        e2d_ready;
    logic        d2e_valid, d2e_illegal, dbg_pipeline_busy;
    logic [`F2E_TYPE_WIDTH-1:0] d2e_type;
    logic [31:0] d2e_instr, d2e_pc;
    logic [3:0]  d2e_resp;
    logic [4:0]  rs1_addr, rs2_addr;

    armleocpu_decode dut (
        .clk(clk), .rst(rst),
        .f2d_valid(f2d_valid), .f2d_type(f2d_type), .f2d_instr(f2d_instr),
        .f2d_pc(f2d_pc), .f2d_resp(f2d_resp),
        .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd), .d2f_branchtarget(d2f_branchtarget),
        .e2d_ready(e2d_ready), .e2d_cmd(e2d_cmd), .e2d_branchtarget(e2d_branchtarget),
        .d2e_valid(d2e_valid), .d2e_type(d2e_type), .d2e_instr(d2e_instr),
        .d2e_pc(d2e_pc), .d2e_resp(d2e_resp), .d2e_illegal(d2e_illegal),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .dbg_pipeline_busy(dbg_pipeline_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the single slot seen by execute, plus whether fetch is held
    logic        m_valid, m_hold, m_ill;
    logic [`F2E_TYPE_WIDTH-1:0] m_type;
    logic [31:0] m_instr, m_pc;
    logic [3:0]  m_resp;

    logic [6:0] opcodes [0:12];
    initial begin
        opcodes = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                    7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F, 7'h0B};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_serializing(input logic [`F2E_TYPE_WIDTH-1:0] ty,
                                             input logic [31:0] ins, input logic [3:0] rsp);
        return (ty == 1) || (rsp != 0) || (ins[6:0] == 7'h73) || (ins[6:0] == 7'h0F);
    endfunction

    function automatic logic ref_illegal(input logic [`F2E_TYPE_WIDTH-1:0] ty,
                                         input logic [31:0] ins, input logic [3:0] rsp);
        logic bad;
        bad = (ins[1:0] != 2'b11);
`ifdef ARMLEOCPU_DECODE_OPCODE_CHECK_EN
        if (!(ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73}))
            bad = 1'b1;
        if (ins[6:0] == 7'h33 && !(ins[31:25] inside {7'h00, 7'h20}))
            bad = 1'b1;
`endif
        return bad && (ty == 0) && (rsp == 0);
    endfunction

    task automatic drive(input logic fv, input logic [`F2E_TYPE_WIDTH-1:0] ty, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [3:0] rsp, input logic er,
                         input logic [1:0] cmd, input logic [31:0] bt);
        f2d_valid = fv; f2d_type = ty; f2d_instr = ins; f2d_pc = pc; f2d_resp = rsp;
        e2d_ready = er; e2d_cmd = cmd; e2d_branchtarget = bt;
    endtask

    // Called 1 time unit after a rising edge with inputs applied; checks mid-cycle, then after the edge
    task automatic step();
        logic fwd, rdy, take, r, fv, er;
        logic [1:0]  ecmd;
        logic [4:0]  e_rs1, e_rs2;
        logic [`F2E_TYPE_WIDTH-1:0] ty;
        logic [31:0] ins, pc;
        logic [3:0]  rsp;
        #4;
        r = rst; fv = f2d_valid; er = e2d_ready;
        ty = f2d_type; ins = f2d_instr; pc = f2d_pc; rsp = f2d_resp;
        fwd  = er && (e2d_cmd != 0);
        rdy  = r ? 1'b0 : (fwd ? 1'b1 : (m_hold ? 1'b0 : (!m_valid || er)));
        ecmd = (!r && fwd) ? e2d_cmd : 2'd0;
        e_rs1 = (rdy && fv) ? ins[19:15] : m_instr[19:15];
        e_rs2 = (rdy && fv) ? ins[24:20] : m_instr[24:20];
        chk("d2f_ready", 32'(d2f_ready), 32'(rdy));
        chk("d2f_cmd", 32'(d2f_cmd), 32'(ecmd));
        if (ecmd != 0) chk("d2f_branchtarget", d2f_branchtarget, e2d_branchtarget);
        if (!r) begin
            chk("rs1_addr", 32'(rs1_addr), 32'(e_rs1));
            chk("rs2_addr", 32'(rs2_addr), 32'(e_rs2));
            chk("dbg_pipeline_busy", 32'(dbg_pipeline_busy), 32'(m_valid || m_hold));
        end
        take = fv && rdy && !fwd;
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_hold = 0; m_ill = 0; m_type = 0; m_instr = 0; m_pc = 0; m_resp = 0;
        end else if (fwd) begin
            m_valid = 0; m_hold = 0;
        end else if (take) begin
            m_valid = 1; m_type = ty; m_instr = ins; m_pc = pc; m_resp = rsp;
            m_ill = ref_illegal(ty, ins, rsp);
            m_hold = ref_serializing(ty, ins, rsp);
        end else if (er) begin
            m_valid = 0; m_hold = 0;
        end
        chk("d2e_valid", 32'(d2e_valid), 32'(m_valid));
        chk("d2e_pc", d2e_pc, m_pc);
        chk("d2e_instr", d2e_instr, m_instr);
        chk("d2e_type", 32'(d2e_type), 32'(m_type));
        chk("d2e_resp", 32'(d2e_resp), 32'(m_resp));
        chk("d2e_illegal", 32'(d2e_illegal), 32'(m_ill));
    endtask

    initial begin
        logic [31:0] ins;
        m_valid = 0; m_hold = 0; m_ill = 0; m_type = 0; m_instr = 0; m_pc = 0; m_resp = 0;
        rst = 1'b1;
        drive(1, 0, 32'h00100093, 32'h1000, 0, 1, 2'd1, 32'h2000);
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;

        // ADDI stream at full throughput
        drive(1, 0, 32'h00100093, 32'h1000, 0, 1, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h1004, 0, 1, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h1008, 0, 1, 0, 0); step();
        drive(1, 0, 32'h00A58513, 32'h100C, 0, 1, 0, 0); step();

        // Execute stalls for three cycles with d2e full
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h00308193, 32'h1010, 0, 0, 0, 0); step();
        end
        drive(1, 0, 32'h00308193, 32'h1010, 0, 1, 0, 0); step();

        // CSR write serializes until execute consumes it
        drive(1, 0, 32'h30001073, 32'h1014, 0, 1, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h1018, 0, 0, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h1018, 0, 0, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h1018, 0, 1, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h1018, 0, 1, 0, 0); step();

        // Branch from execute overrides a presented fetch word
        drive(1, 0, 32'h00100093, 32'h101C, 0, 1, 2'd1, 32'h2000); step();
        drive(0, 0, 32'h00100093, 32'h2000, 0, 1, 0, 0); step();

        // Pending interrupt holds fetch, then a flush is forwarded
        drive(1, 1, 32'h0, 32'h2000, 0, 1, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h2004, 0, 0, 0, 0); step();
        drive(1, 0, 32'h00100093, 32'h2004, 0, 1, 2'd2, 32'h3000); step();

        // Illegal encodings and a faulting fetch
        drive(1, 0, 32'h00000000, 32'h3000, 0, 1, 0, 0); step();
        drive(1, 0, 32'h0000007F, 32'h3004, 0, 1, 0, 0); step();
        drive(1, 0, 32'h00000000, 32'h3008, 4'h2, 1, 0, 0); step();
        drive(0, 0, 32'h0, 32'h0, 0, 1, 0, 0); step();

        // Reset while holding a FENCE
        drive(1, 0, 32'h0000000F, 32'h300C, 0, 1, 0, 0); step();
        rst = 1'b1; drive(1, 0, 32'h00100093, 32'h3010, 0, 0, 0, 0); step();
        rst = 1'b0; step();

        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            ins[6:0] = opcodes[$urandom_range(0, 12)];
            if ($urandom_range(0, 9) == 0) ins[1:0] = 2'($urandom_range(0, 2));
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0,
                  `F2E_TYPE_WIDTH'($urandom_range(0, 15) == 0),
                  ins, $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0,
                  $urandom & 32'hFFFF_FFFC);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
